uibi_master_port: RTL and testbench

UIBI_MASTER_PORT -- requirements
Module: uibi_master_port

---
 rtl/uibi_pkg.sv | 62 ++++++
 rtl/uibi_master_port_if.sv | 47 ++++
 rtl/uibi_lane_align.sv | 49 ++++
 rtl/uibi_master_port.sv | 161 ++++++++++++++++
 tb/tb_uibi_master_port.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uibi_pkg.sv
// Shared UIBI definitions: access size encodings, bus_mode codes, master FSM
// states, the captured CPU request payload and small decode helpers.
package uibi_pkg;

  localparam int unsigned UIBI_XLEN = 32;

  // CPU access size encoding
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;

  // bus_mode lane-enable style codes
  localparam logic [2:0] MODE_BYTE = 3'b001;
  localparam logic [2:0] MODE_HALF = 3'b011;
  localparam logic [2:0] MODE_WORD = 3'b111;

  // Master port FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Request captured on acceptance
  typedef struct packed {
    logic [UIBI_XLEN-1:0] addr;
    logic [UIBI_XLEN-1:0] wdata;
    logic                 wen;
    logic [1:0]           size;
    logic                 sgn;
  } cpu_req_t;

  // Legal size and natural alignment
  function automatic logic access_legal(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (size_e'(size))
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = ~off[0];
      SIZE_WORD: ok = (off == 2'b00);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Size to bus_mode code
  function automatic logic [2:0] size_to_mode(input logic [1:0] size);
    logic [2:0] m;
    m = 3'b000;
    case (size_e'(size))
      SIZE_BYTE: m = MODE_BYTE;
      SIZE_HALF: m = MODE_HALF;
      SIZE_WORD: m = MODE_WORD;
      default:   m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/uibi_master_port_if.sv
// CPU request/response handshake plus UIBI master bus signals.
// master modport: the view of uibi_master_port.
// slave modport : the view of the CPU + bus slave environment.
//   cpu_valid/cpu_ready, cpu_addr/wdata/wen/size/signed : request
//   rsp_valid/rsp_rdata/rsp_err                         : completion
//   bus_dat_i/bus_ready (to master), bus_dat_o/addr/num/req/wen/mode (from master)
interface uibi_master_port_if #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned SLAVE_WIDTH = 4
);

  logic                    cpu_valid;
  logic                    cpu_ready;
  logic [XLEN-1:0]         cpu_addr;
  logic [XLEN-1:0]         cpu_wdata;
  logic                    cpu_wen;
  logic [1:0]              cpu_size;
  logic                    cpu_signed;

  logic                    rsp_valid;
  logic [XLEN-1:0]         rsp_rdata;
  logic                    rsp_err;

  logic [XLEN-1:0]         bus_dat_i;
  logic [XLEN-1:0]         bus_dat_o;
  logic [XLEN-SLAVE_WIDTH-1:0] bus_addr;
  logic [SLAVE_WIDTH-1:0]  bus_num;
  logic                    bus_req;
  logic                    bus_wen;
  logic [2:0]              bus_mode;
  logic                    bus_ready;

  modport master (
    input  cpu_valid, cpu_addr, cpu_wdata, cpu_wen, cpu_size, cpu_signed,
    output cpu_ready, rsp_valid, rsp_rdata, rsp_err,
    input  bus_dat_i, bus_ready,
    output bus_dat_o, bus_addr, bus_num, bus_req, bus_wen, bus_mode
  );

  modport slave (
    output cpu_valid, cpu_addr, cpu_wdata, cpu_wen, cpu_size, cpu_signed,
    input  cpu_ready, rsp_valid, rsp_rdata, rsp_err,
    output bus_dat_i, bus_ready,
    input  bus_dat_o, bus_addr, bus_num, bus_req, bus_wen, bus_mode
  );

endinterface

// File: rtl/uibi_lane_align.sv
// Combinational byte-lane alignment shared by UIBI masters.
//   i_size/i_off/i_signed : access size, byte offset, sign-extend loads
//   i_wdata -> o_wlane_c  : right-aligned store data placed on its lanes
//   i_rdata -> o_rdata_c  : bus word shifted down, masked and extended
module uibi_lane_align
  import uibi_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      i_size,
  input  logic [1:0]      i_off,
  input  logic            i_signed,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_wlane_c,
  output logic [XLEN-1:0] o_rdata_c
);

  logic [4:0]      w_sh;
  logic [XLEN-1:0] w_rshift;

  assign w_sh     = {i_off, 3'b000};
  assign w_rshift = i_rdata >> w_sh;

  // Truncate before shifting so unused lanes stay zero
  always_comb begin
    o_wlane_c = '0;
    o_rdata_c = '0;
    case (size_e'(i_size))
      SIZE_BYTE: begin
        o_wlane_c = XLEN'(i_wdata[7:0]) << w_sh;
        o_rdata_c = {{(XLEN-8){i_signed & w_rshift[7]}}, w_rshift[7:0]};
      end
      SIZE_HALF: begin
        o_wlane_c = XLEN'(i_wdata[15:0]) << w_sh;
        o_rdata_c = {{(XLEN-16){i_signed & w_rshift[15]}}, w_rshift[15:0]};
      end
      SIZE_WORD: begin
        o_wlane_c = i_wdata << w_sh;
        o_rdata_c = w_rshift;
      end
      default: begin
        o_wlane_c = '0;
        o_rdata_c = '0;
      end
    endcase
  end

endmodule

// File: rtl/uibi_master_port.sv
// UIBI master port: accepts one CPU load/store at a time, runs it on the
// UIBI bus with a timeout, and returns a one-cycle response pulse.
//   clk, rst_n : clock, synchronous active-low reset
//   u_if       : CPU request/response and UIBI bus signals (master view)
module uibi_master_port
  import uibi_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned SLAVE_WIDTH = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  uibi_master_port_if.master u_if
);

  localparam int unsigned AW    = XLEN - SLAVE_WIDTH;
  localparam int unsigned CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  cpu_req_t         r_req;
  cpu_req_t         w_req_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             w_accept;
  logic             w_err_nxt;
  logic [XLEN-1:0]  w_rdata_nxt;
  logic [XLEN-1:0]  w_wlane;
  logic [XLEN-1:0]  w_load;

  logic             r_cpu_ready;
  logic             r_rsp_valid;
  logic             r_rsp_err;
  logic [XLEN-1:0]  r_rsp_rdata;
  logic             r_bus_req;
  logic             r_bus_wen;
  logic [2:0]       r_bus_mode;
  logic [SLAVE_WIDTH-1:0] r_bus_num;
  logic [AW-1:0]    r_bus_addr;
  logic [XLEN-1:0]  r_bus_dat_o;

  // Live CPU inputs while idle (the accept cycle), captured request otherwise
  always_comb begin
    w_req_sel = r_req;
    if (r_state == ST_IDLE) begin
      w_req_sel.addr  = u_if.cpu_addr;
      w_req_sel.wdata = u_if.cpu_wdata;
      w_req_sel.wen   = u_if.cpu_wen;
      w_req_sel.size  = u_if.cpu_size;
      w_req_sel.sgn   = u_if.cpu_signed;
    end
  end

  uibi_lane_align #(.XLEN(XLEN)) u_lane_align (
    .i_size    (w_req_sel.size),
    .i_off     (w_req_sel.addr[1:0]),
    .i_signed  (w_req_sel.sgn),
    .i_wdata   (w_req_sel.wdata),
    .i_rdata   (u_if.bus_dat_i),
    .o_wlane_c (w_wlane),
    .o_rdata_c (w_load)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, response payload and timeout counter
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_err_nxt   = 1'b0;
    w_rdata_nxt = '0;
    w_cnt_nxt   = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (u_if.cpu_valid) begin
          w_accept = 1'b1;
          if (access_legal(u_if.cpu_size, u_if.cpu_addr[1:0])) begin
            w_state_nxt = ST_BUS;
          end else begin
            w_state_nxt = ST_RESP;
            w_err_nxt   = 1'b1;
          end
        end
      end
      ST_BUS: begin
        // Ready wins over timeout on the final allowed cycle
        if (u_if.bus_ready) begin
          w_state_nxt = ST_RESP;
          w_rdata_nxt = r_req.wen ? '0 : w_load;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_RESP;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Captured request and registered outputs, all derived from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req       <= '0;
      r_cnt       <= '0;
      r_cpu_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_bus_req   <= 1'b0;
      r_bus_wen   <= 1'b0;
      r_bus_mode  <= '0;
      r_bus_num   <= '0;
      r_bus_addr  <= '0;
      r_bus_dat_o <= '0;
    end else begin
      if (w_accept) r_req <= w_req_sel;
      r_cnt       <= w_cnt_nxt;
      r_cpu_ready <= (w_state_nxt == ST_IDLE);
      r_rsp_valid <= (w_state_nxt == ST_RESP);
      r_rsp_err   <= w_err_nxt;
      r_rsp_rdata <= w_rdata_nxt;
      if (w_state_nxt == ST_BUS) begin
        r_bus_req   <= 1'b1;
        r_bus_wen   <= w_req_sel.wen;
        r_bus_mode  <= size_to_mode(w_req_sel.size);
        r_bus_num   <= w_req_sel.addr[XLEN-1 -: SLAVE_WIDTH];
        r_bus_addr  <= w_req_sel.addr[AW-1:0];
        // Loads carry no write data
        r_bus_dat_o <= w_req_sel.wen ? w_wlane : '0;
      end else begin
        r_bus_req   <= 1'b0;
        r_bus_wen   <= 1'b0;
        r_bus_mode  <= '0;
        r_bus_num   <= '0;
        r_bus_addr  <= '0;
        r_bus_dat_o <= '0;
      end
    end
  end

  assign u_if.cpu_ready = r_cpu_ready;
  assign u_if.rsp_valid = r_rsp_valid;
  assign u_if.rsp_err   = r_rsp_err;
  assign u_if.rsp_rdata = r_rsp_rdata;
  assign u_if.bus_req   = r_bus_req;
  assign u_if.bus_wen   = r_bus_wen;
  assign u_if.bus_mode  = r_bus_mode;
  assign u_if.bus_num   = r_bus_num;
  assign u_if.bus_addr  = r_bus_addr;
  assign u_if.bus_dat_o = r_bus_dat_o;

endmodule

// File: tb/tb_uibi_master_port.sv
// Bench for uibi_master_port: directed and random loads/stores against a
// transaction-level timeline model, with a reactive slave of random latency.
module tb_uibi_master_port;

  localparam int TO = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic [1:0]  size;
    logic        sgn;
    int          d;
    logic [31:0] rd;
  } txn_t;

  logic clk;
  logic rst_n;

  uibi_master_port_if #(.XLEN(32), .SLAVE_WIDTH(4)) u_if ();

  uibi_master_port #(.XLEN(32), .SLAVE_WIDTH(4), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .u_if  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  txn_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          s_delay = 0;
  logic [31:0] s_rdata = '0;
  int          obs_req = 0;
  int          obs_rsp = 0;
  logic [31:0] last_rdata, last_dato;
  logic        last_err, last_wen;
  logic [2:0]  last_mode;
  logic [3:0]  last_num;

  task automatic chk(input string nm, input logic [103:0] act, input logic [103:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic legal(input txn_t t);
    if (t.size == 2'd3) return 1'b0;
    if (t.size == 2'd1 && t.addr[0]) return 1'b0;
    if (t.size == 2'd2 && t.addr[1:0] != 2'd0) return 1'b0;
    return 1'b1;
  endfunction

  // Number of cycles bus_req is expected high for this transaction
  function automatic int nbus(input txn_t t);
    if (!legal(t)) return 0;
    return (t.d < TO) ? t.d + 1 : TO;
  endfunction

  function automatic logic terr(input txn_t t);
    return !legal(t) || (t.d >= TO);
  endfunction

  function automatic logic [31:0] load_val(input txn_t t);
    logic [31:0] v;
    v = t.rd >> (8 * t.addr[1:0]);
    if (t.size == 2'd0) begin
      v = v & 32'h0000_00FF;
      if (t.sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (t.size == 2'd1) begin
      v = v & 32'h0000_FFFF;
      if (t.sgn && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Expected outputs k cycles after acceptance (or idle when not busy)
  function automatic logic [103:0] expect_vec(input logic busy, input int k, input txn_t t);
    logic cr, rv, re, br, bw;
    logic [31:0] rd, bd, mask;
    logic [2:0]  bm;
    logic [3:0]  bn;
    logic [27:0] ba;
    int nb;
    cr = !busy; rv = 0; re = 0; br = 0; bw = 0;
    rd = '0; bd = '0; bm = '0; bn = '0; ba = '0;
    if (busy) begin
      nb = nbus(t);
      if (k <= nb) begin
        br = 1'b1;
        bw = t.wen;
        bm = (t.size == 2'd0) ? 3'b001 : (t.size == 2'd1) ? 3'b011 : 3'b111;
        bn = t.addr[31:28];
        ba = t.addr[27:0];
        mask = (t.size == 2'd0) ? 32'hFF : (t.size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        bd = t.wen ? ((t.wdata & mask) << (8 * t.addr[1:0])) : 32'h0;
      end else if (k == nb + 1) begin
        rv = 1'b1;
        re = terr(t);
        rd = (re || t.wen) ? 32'h0 : load_val(t);
      end
    end
    return {cr, rv, re, rd, br, bw, bm, bn, ba, bd};
  endfunction

  // Compare process: sample handshake before the edge, outputs 1 ns after it
  initial begin : model
    logic busy;
    int   k;
    txn_t cur;
    logic pre_rst, pre_acc;
    busy = 1'b0;
    k    = 0;
    cur  = '{default: '0};
    forever begin
      @(posedge clk);
      pre_rst = rst_n;
      pre_acc = (u_if.cpu_valid === 1'b1) && (u_if.cpu_ready === 1'b1);
      #1;
      if (busy) begin
        k++;
        if (k > nbus(cur) + 1) busy = 1'b0;
      end
      if (pre_rst !== 1'b1) begin
        busy = 1'b0;
      end else if (pre_acc) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_accept @%0t: got accept want none", $time);
        end else begin
          cur     = q.pop_front();
          busy    = 1'b1;
          k       = 1;
          obs_req = 0;
        end
      end
      chk("cycle", {u_if.cpu_ready, u_if.rsp_valid, u_if.rsp_err, u_if.rsp_rdata,
                    u_if.bus_req, u_if.bus_wen, u_if.bus_mode, u_if.bus_num,
                    u_if.bus_addr, u_if.bus_dat_o},
          expect_vec(busy, k, cur));
      if (u_if.bus_req === 1'b1) begin
        obs_req++;
        last_num  = u_if.bus_num;
        last_mode = u_if.bus_mode;
        last_dato = u_if.bus_dat_o;
        last_wen  = u_if.bus_wen;
      end
      if (u_if.rsp_valid === 1'b1) begin
        obs_rsp++;
        last_rdata = u_if.rsp_rdata;
        last_err   = u_if.rsp_err;
      end
    end
  end

  // Reactive slave: ready on bus cycle s_delay, noise whenever bus_req is low
  initial begin : slave
    int s_cnt;
    s_cnt = 0;
    u_if.bus_ready = 1'b0;
    u_if.bus_dat_i = '0;
    forever begin
      @(negedge clk);
      if (u_if.bus_req === 1'b1) begin
        u_if.bus_ready = (s_cnt == s_delay);
        u_if.bus_dat_i = u_if.bus_ready ? s_rdata : $urandom;
        s_cnt++;
      end else begin
        s_cnt = 0;
        u_if.bus_ready = 1'($urandom);
        u_if.bus_dat_i = $urandom;
      end
    end
  end

  // Wait for cpu_ready, waving ignored requests while the bus is busy
  task automatic wait_ready();
    for (int i = 0; i < 60; i++) begin
      if (u_if.cpu_ready === 1'b1) begin
        u_if.cpu_valid = 1'b0;
        return;
      end
      if (u_if.bus_req === 1'b1) begin
        u_if.cpu_valid  = 1'($urandom);
        u_if.cpu_addr   = $urandom;
        u_if.cpu_wdata  = $urandom;
        u_if.cpu_wen    = 1'($urandom);
        u_if.cpu_size   = 2'($urandom);
        u_if.cpu_signed = 1'($urandom);
      end else begin
        u_if.cpu_valid = 1'b0;
      end
      @(negedge clk);
    end
    n_tests++;
    n_fail++;
    $display("FAIL ready_timeout @%0t: got cpu_ready low want high within 60 cycles", $time);
    u_if.cpu_valid = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input logic [1:0] sz, input logic sg, input int d, input logic [31:0] rd);
    txn_t t;
    t.addr = a; t.wdata = wd; t.wen = we; t.size = sz; t.sgn = sg; t.d = d; t.rd = rd;
    q.push_back(t);
    s_delay = d;
    s_rdata = rd;
    u_if.cpu_valid  = 1'b1;
    u_if.cpu_addr   = a;
    u_if.cpu_wdata  = wd;
    u_if.cpu_wen    = we;
    u_if.cpu_size   = sz;
    u_if.cpu_signed = sg;
    @(negedge clk);
    u_if.cpu_valid = 1'b0;
  endtask

  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic we,
                         input logic [1:0] sz, input logic sg, input int d, input logic [31:0] rd);
    wait_ready();
    issue(a, wd, we, sz, sg, d, rd);
    wait_ready();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog @%0t: got no finish want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] a;
    logic [1:0]  sz;
    int          r, rsp0;
    rst_n = 1'b0;
    u_if.cpu_valid = 1'b0;
    u_if.cpu_addr = '0; u_if.cpu_wdata = '0; u_if.cpu_wen = 1'b0;
    u_if.cpu_size = '0; u_if.cpu_signed = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Word load, slave ready on third bus cycle
    run_txn(32'h1000_0008, 32'h5555_5555, 1'b0, 2'b10, 1'b0, 2, 32'hDEAD_BEEF);
    chk("word_load_num", 104'(last_num), 104'(4'h1));
    chk("word_load_mode", 104'(last_mode), 104'(3'b111));
    chk("word_load_rdata", 104'(last_rdata), 104'(32'hDEAD_BEEF));
    chk("word_load_err", 104'(last_err), 104'(1'b0));
    chk("word_load_reqcyc", 104'(obs_req), 104'(3));

    // Byte loads at offset 3, signed then unsigned
    run_txn(32'h2000_0013, 32'h0, 1'b0, 2'b00, 1'b1, 0, 32'h80AB_CDEF);
    chk("sbyte_rdata", 104'(last_rdata), 104'(32'hFFFF_FF80));
    run_txn(32'h2000_0013, 32'h0, 1'b0, 2'b00, 1'b0, 1, 32'h80AB_CDEF);
    chk("ubyte_rdata", 104'(last_rdata), 104'(32'h0000_0080));

    // Half store at offset 2
    run_txn(32'h3000_0002, 32'h1234_ABCD, 1'b1, 2'b01, 1'b0, 1, 32'hFFFF_FFFF);
    chk("hstore_dato", 104'(last_dato), 104'(32'hABCD_0000));
    chk("hstore_mode", 104'(last_mode), 104'(3'b011));
    chk("hstore_wen", 104'(last_wen), 104'(1'b1));
    chk("hstore_rdata", 104'(last_rdata), 104'(32'h0));

    // Misaligned word and illegal size: no bus activity, error response
    run_txn(32'h4000_0001, 32'h0, 1'b0, 2'b10, 1'b0, 0, 32'h1234_5678);
    chk("misalign_reqcyc", 104'(obs_req), 104'(0));
    chk("misalign_err", 104'(last_err), 104'(1'b1));
    run_txn(32'h4000_0000, 32'h0, 1'b0, 2'b11, 1'b0, 0, 32'h1234_5678);
    chk("illsize_reqcyc", 104'(obs_req), 104'(0));
    chk("illsize_err", 104'(last_err), 104'(1'b1));

    // Slave never ready: timeout after TO bus cycles
    run_txn(32'h5000_0000, 32'h0, 1'b0, 2'b10, 1'b0, 1000, 32'hCAFE_F00D);
    chk("timeout_reqcyc", 104'(obs_req), 104'(4));
    chk("timeout_err", 104'(last_err), 104'(1'b1));
    chk("timeout_rdata", 104'(last_rdata), 104'(32'h0));

    // Ready on the last allowed cycle still completes
    run_txn(32'h6000_0004, 32'h0, 1'b0, 2'b10, 1'b0, 3, 32'h0BAD_F00D);
    chk("lastcyc_reqcyc", 104'(obs_req), 104'(4));
    chk("lastcyc_err", 104'(last_err), 104'(1'b0));
    chk("lastcyc_rdata", 104'(last_rdata), 104'(32'h0BAD_F00D));

    // Reset during the bus phase abandons the transfer
    wait_ready();
    issue(32'h7000_0000, 32'h0, 1'b0, 2'b10, 1'b0, 1000, 32'h0);
    @(negedge clk);
    rsp0  = obs_rsp;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_busreq", 104'(u_if.bus_req), 104'(1'b0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 104'(u_if.cpu_ready), 104'(1'b1));
    chk("rst_norsp", 104'(obs_rsp), 104'(rsp0));

    // Random mix, mostly aligned, random slave latency
    for (int i = 0; i < 150; i++) begin
      r  = $urandom_range(0, 15);
      sz = (r == 0) ? 2'b11 : 2'(r % 3);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      run_txn(a, $urandom, 1'($urandom), sz, 1'($urandom), $urandom_range(0, 5), $urandom);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
